// File: rtl/simple_filter_pkg.sv
// Shared types for the simple_filter signal conditioner: debug view of the
// filter state and the counter-width helper.
package simple_filter_pkg;

  // Wide enough for any legal FILTER_CYCLES (max 255 -> 8-bit counter).
  localparam int DBG_CNT_W = 8;

  typedef struct packed {
    logic [DBG_CNT_W-1:0] cnt;       // persistence counter, zero-extended
    logic                 s;         // synchronized input
    logic                 mismatch;  // s differs from outSignal this cycle
  } filter_dbg_t;

  function automatic int cnt_width(input int filter_cycles);
    return $clog2(filter_cycles + 1);
  endfunction

endpackage

// File: rtl/simple_filter_if.sv
// Level-signal bundle between a raw board input and its conditioned copy.
// There is no handshake: both signals are plain levels, sampled every cycle.
interface simple_filter_if;
  logic inSignal;
  logic outSignal;

  modport master (output inSignal, input outSignal);
  modport slave  (input inSignal, output outSignal);
endinterface

// File: rtl/simple_sync.sv
// Reset-clearable multi-flop synchronizer for one asynchronous level input.
// Deliberately contains nothing but flops between stages.
module simple_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  if (STAGES < 2) begin : g_bad_stages
    $error("simple_sync: STAGES must be at least 2");
  end

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk) begin
    if (reset) begin
      chain <= '0;
    end else begin
      chain <= {chain[STAGES-2:0], d};
    end
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/simple_filter.sv
// Glitch filter: synchronizer, then a persistence counter that flips the
// registered output only after FILTER_CYCLES consecutive mismatching cycles.
module simple_filter
  import simple_filter_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  simple_filter_if.slave        fil,
  output filter_dbg_t           dbg
);

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync
    $error("simple_filter: SYNC_STAGES must be in 2..4");
  end
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > 255) begin : g_bad_filter
    $error("simple_filter: FILTER_CYCLES must be in 1..255");
  end

  localparam int CW = cnt_width(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_CYCLES - 1);

  logic          s;
  logic          out_q;
  logic [CW-1:0] cnt;
  logic          mismatch;

  simple_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (fil.inSignal),
    .q     (s)
  );

  assign mismatch = (s != out_q);

  // The flip decision uses the current s, so a return to match on the
  // completing cycle cancels the flip. cnt therefore never passes CNT_LAST.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt   <= '0;
      out_q <= 1'b0;
    end else if (!mismatch) begin
      cnt <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt   <= '0;
      out_q <= s;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign fil.outSignal = out_q;

  assign dbg.cnt      = DBG_CNT_W'(cnt);
  assign dbg.s        = s;
  assign dbg.mismatch = mismatch;

endmodule

// File: tb/tb_simple_filter.sv
// Directed bench for simple_filter: default instance plus a
// SYNC_STAGES=3 / FILTER_CYCLES=1 instance, hand-computed expectations.
module tb_simple_filter;
  import simple_filter_pkg::*;

  logic clk;
  logic reset;
  filter_dbg_t dbg_def;
  filter_dbg_t dbg_fast;

  int checks;
  int errors;

  simple_filter_if fil_def ();
  simple_filter_if fil_fast ();

  simple_filter u_def (
    .clk   (clk),
    .reset (reset),
    .fil   (fil_def.slave),
    .dbg   (dbg_def)
  );

  simple_filter #(
    .SYNC_STAGES   (3),
    .FILTER_CYCLES (1)
  ) u_fast (
    .clk   (clk),
    .reset (reset),
    .fil   (fil_fast.slave),
    .dbg   (dbg_fast)
  );

  // clock/reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  task automatic check_eq(input string tag, input logic [31:0] got,
                          input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // driver tasks: advance n rising edges, then settle 1 time unit
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    int first_rise;
    int hi_cycles;
    int peak;
    checks = 0;
    errors = 0;

    // Reset held 3 edges with input high: everything stays cleared
    reset = 1'b1;
    fil_def.inSignal  = 1'b1;
    fil_fast.inSignal = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("rst_out", 32'(fil_def.outSignal), 0);
      check_eq("rst_cnt", 32'(dbg_def.cnt), 0);
    end
    check_eq("rst_fast_out", 32'(fil_fast.outSignal), 0);

    // Release: input already high, rises 6 edges later
    reset = 1'b0;
    step(5);
    check_eq("rel_out_e5", 32'(fil_def.outSignal), 0);
    step(1);
    check_eq("rel_out_e6", 32'(fil_def.outSignal), 1);

    // Return low and let it settle
    fil_def.inSignal = 1'b0;
    step(5);
    check_eq("fall_out_e5", 32'(fil_def.outSignal), 1);
    step(1);
    check_eq("fall_out_e6", 32'(fil_def.outSignal), 0);
    step(4);

    // Clean 20-cycle pulse: latency 6 both ways, width preserved
    first_rise = -1;
    hi_cycles  = 0;
    fil_def.inSignal = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (i == 20) fil_def.inSignal = 1'b0;
      step(1);
      if (fil_def.outSignal && first_rise < 0) first_rise = i + 1;
      if (fil_def.outSignal) hi_cycles++;
    end
    check_eq("pulse_latency", 32'(first_rise), 6);
    check_eq("pulse_width", 32'(hi_cycles), 20);
    check_eq("pulse_end_out", 32'(fil_def.outSignal), 0);

    // Glitch of 3 cycles: count peaks at 3, output never moves
    peak = 0;
    hi_cycles = 0;
    fil_def.inSignal = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (i == 3) fil_def.inSignal = 1'b0;
      step(1);
      if (int'(dbg_def.cnt) > peak) peak = int'(dbg_def.cnt);
      if (fil_def.outSignal) hi_cycles++;
    end
    check_eq("glitch_peak", 32'(peak), 3);
    check_eq("glitch_out_hi", 32'(hi_cycles), 0);
    check_eq("glitch_cnt_end", 32'(dbg_def.cnt), 0);

    // Count restart: high 3, low 1, high -> rise 6 edges after second rise
    fil_def.inSignal = 1'b1;
    step(3);
    fil_def.inSignal = 1'b0;
    step(1);
    fil_def.inSignal = 1'b1;
    first_rise = -1;
    for (int i = 0; i < 10; i++) begin
      step(1);
      if (fil_def.outSignal && first_rise < 0) first_rise = i + 1;
    end
    check_eq("restart_latency", 32'(first_rise), 6);
    fil_def.inSignal = 1'b0;
    step(10);
    check_eq("restart_settle", 32'(fil_def.outSignal), 0);

    // Reset mid-count discards the partial count
    fil_def.inSignal = 1'b1;
    step(4);
    check_eq("mid_cnt2", 32'(dbg_def.cnt), 2);
    reset = 1'b1;
    step(1);
    check_eq("mid_rst_out", 32'(fil_def.outSignal), 0);
    check_eq("mid_rst_cnt", 32'(dbg_def.cnt), 0);
    reset = 1'b0;
    step(5);
    check_eq("mid_rel_e5", 32'(fil_def.outSignal), 0);
    step(1);
    check_eq("mid_rel_e6", 32'(fil_def.outSignal), 1);
    fil_def.inSignal = 1'b0;
    step(10);

    // SYNC_STAGES=3, FILTER_CYCLES=1: 4-edge tracking, glitch passes through
    fil_fast.inSignal = 1'b1;
    step(3);
    check_eq("fast_rise_e3", 32'(fil_fast.outSignal), 0);
    step(1);
    check_eq("fast_rise_e4", 32'(fil_fast.outSignal), 1);
    fil_fast.inSignal = 1'b0;
    step(3);
    check_eq("fast_fall_e3", 32'(fil_fast.outSignal), 1);
    step(1);
    check_eq("fast_fall_e4", 32'(fil_fast.outSignal), 0);
    step(3);
    fil_fast.inSignal = 1'b1;
    step(1);
    fil_fast.inSignal = 1'b0;
    step(2);
    check_eq("fast_glitch_pre", 32'(fil_fast.outSignal), 0);
    step(1);
    check_eq("fast_glitch_hi", 32'(fil_fast.outSignal), 1);
    step(1);
    check_eq("fast_glitch_lo", 32'(fil_fast.outSignal), 0);
    check_eq("fast_cnt", 32'(dbg_fast.cnt), 0);
    check_eq("def_idle_out", 32'(fil_def.outSignal), 0);

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
